// File: rtl/idex_hazard_stage_pkg.sv
// Shared types and constants for the ID/EX hazard stage.
// Holds the registered-field struct and its bubble value.
package idex_hazard_stage_pkg;

  localparam int unsigned CTRL_W_DEF = 16;
  localparam int unsigned REG_IDX_W  = 5;
  localparam int unsigned XLEN       = 32;

  // The control bundle width is a per-instance parameter, so it lives beside
  // this struct in the stage rather than inside it.
  typedef struct packed {
    logic                 valid;
    logic [XLEN-1:0]      pc;
    logic [REG_IDX_W-1:0] rs1;
    logic [REG_IDX_W-1:0] rs2;
    logic [REG_IDX_W-1:0] rd;
    logic [XLEN-1:0]      rs1_data;
    logic [XLEN-1:0]      rs2_data;
    logic [XLEN-1:0]      imm;
    logic                 mem_read;
    logic                 reg_write;
  } idex_t;

  localparam idex_t IDEX_BUBBLE = '0;

  typedef enum logic [1:0] {
    SEL_LOAD   = 2'd0,
    SEL_HOLD   = 2'd1,
    SEL_BUBBLE = 2'd2
  } idex_sel_e;

endpackage

// File: rtl/idex_hazard_stage_load_use_detect.sv
// Combinational load-use hazard detector: ID source operand matches a load
// destination currently in EX.
import idex_hazard_stage_pkg::*;

module load_use_detect (
  input  logic                 id_valid,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_uses_rs1,
  input  logic                 id_uses_rs2,
  input  logic                 ex_valid,
  input  logic                 ex_mem_read,
  input  logic [REG_IDX_W-1:0] ex_rd,
  output logic                 hazard
);

  logic rs1_hit;
  logic rs2_hit;

  always_comb begin
    rs1_hit = id_uses_rs1 && (id_rs1 == ex_rd);
    rs2_hit = id_uses_rs2 && (id_rs2 == ex_rd);
    hazard  = id_valid && ex_valid && ex_mem_read && (ex_rd != '0) && (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/idex_hazard_stage.sv
// ID/EX pipeline register with load-use bubble insertion and WB write-through
// bypass. Optional hazard statistics counters under HAZARD_STATS_EN.
import idex_hazard_stage_pkg::*;

module idex_hazard_stage #(
  parameter int unsigned CTRL_W = CTRL_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 id_valid,
  input  logic [XLEN-1:0]      id_pc,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic [REG_IDX_W-1:0] id_rd,
  input  logic                 id_uses_rs1,
  input  logic                 id_uses_rs2,
  input  logic [XLEN-1:0]      id_rs1_data,
  input  logic [XLEN-1:0]      id_rs2_data,
  input  logic [XLEN-1:0]      id_imm,
  input  logic [CTRL_W-1:0]    id_ctrl,
  input  logic                 id_memRead,
  input  logic                 id_regWrite,
  input  logic                 wb_regWrite,
  input  logic [REG_IDX_W-1:0] wb_rd,
  input  logic [XLEN-1:0]      wb_data,
  input  logic                 ex_flush,
  input  logic                 ex_stall,
  output logic                 ex_valid,
  output logic [XLEN-1:0]      ex_pc,
  output logic [REG_IDX_W-1:0] ex_rs1,
  output logic [REG_IDX_W-1:0] ex_rs2,
  output logic [REG_IDX_W-1:0] ex_rd,
  output logic [XLEN-1:0]      ex_rs1_data,
  output logic [XLEN-1:0]      ex_rs2_data,
  output logic [XLEN-1:0]      ex_imm,
  output logic [CTRL_W-1:0]    ex_ctrl,
  output logic                 ex_memRead,
  output logic                 ex_regWrite,
  output logic                 pc_stall,
  output logic                 ifid_stall,
  output logic                 load_use_stall
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]          stall_count,
  output logic [31:0]          flush_count
`endif
);

  idex_t       q;
  idex_t       id_fields;
  logic [CTRL_W-1:0] ctrl_q;
  logic        hazard;
  idex_sel_e   sel;

  load_use_detect u_detect (
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .ex_valid    (q.valid),
    .ex_mem_read (q.mem_read),
    .ex_rd       (q.rd),
    .hazard      (hazard)
  );

  always_comb begin
    id_fields           = IDEX_BUBBLE;
    id_fields.valid     = id_valid;
    id_fields.pc        = id_pc;
    id_fields.rs1       = id_rs1;
    id_fields.rs2       = id_rs2;
    id_fields.rd        = id_rd;
    id_fields.imm       = id_imm;
    id_fields.mem_read  = id_memRead;
    id_fields.reg_write = id_regWrite;
    id_fields.rs1_data  = (wb_regWrite && (wb_rd != '0) && (wb_rd == id_rs1)) ? wb_data : id_rs1_data;
    id_fields.rs2_data  = (wb_regWrite && (wb_rd != '0) && (wb_rd == id_rs2)) ? wb_data : id_rs2_data;
  end

  // Flush outranks stall so a redirect is never held off by a busy memory.
  always_comb begin
    sel = SEL_LOAD;
    if (ex_flush)      sel = SEL_BUBBLE;
    else if (ex_stall) sel = SEL_HOLD;
    else if (hazard)   sel = SEL_BUBBLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q      <= IDEX_BUBBLE;
      ctrl_q <= '0;
    end else begin
      case (sel)
        SEL_BUBBLE: begin
          q      <= IDEX_BUBBLE;
          ctrl_q <= '0;
        end
        SEL_HOLD: begin
        end
        default: begin
          q      <= id_fields;
          ctrl_q <= id_ctrl;
        end
      endcase
    end
  end

  always_comb begin
    pc_stall       = !ex_flush && (ex_stall || hazard);
    ifid_stall     = pc_stall;
    load_use_stall = hazard && !ex_flush && !ex_stall;
  end

  assign ex_valid    = q.valid;
  assign ex_pc       = q.pc;
  assign ex_rs1      = q.rs1;
  assign ex_rs2      = q.rs2;
  assign ex_rd       = q.rd;
  assign ex_rs1_data = q.rs1_data;
  assign ex_rs2_data = q.rs2_data;
  assign ex_imm      = q.imm;
  assign ex_ctrl     = ctrl_q;
  assign ex_memRead  = q.mem_read;
  assign ex_regWrite = q.reg_write;

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (load_use_stall && (stall_count != '1)) stall_count <= stall_count + 32'd1;
      if (ex_flush && q.valid && (flush_count != '1)) flush_count <= flush_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_idex_hazard_stage.sv
// Scoreboard bench for idex_hazard_stage: expected EX contents are pushed when
// stimulus is applied and popped after the capturing edge.
module tb_idex_hazard_stage;

  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          id_valid, id_uses_rs1, id_uses_rs2, id_memRead, id_regWrite;
  logic [31:0]   id_pc, id_rs1_data, id_rs2_data, id_imm, wb_data;
  logic [4:0]    id_rs1, id_rs2, id_rd, wb_rd;
  logic [CW-1:0] id_ctrl;
  logic          wb_regWrite, ex_flush, ex_stall;
  logic          ex_valid, ex_memRead, ex_regWrite;
  logic [31:0]   ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]    ex_rs1, ex_rs2, ex_rd;
  logic [CW-1:0] ex_ctrl;
  logic          pc_stall, ifid_stall, load_use_stall;
`ifdef HAZARD_STATS_EN
  logic [31:0]   stall_count, flush_count;
`endif

  idex_hazard_stage #(.CTRL_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_ctrl(id_ctrl),
    .id_memRead(id_memRead), .id_regWrite(id_regWrite),
    .wb_regWrite(wb_regWrite), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_flush(ex_flush), .ex_stall(ex_stall),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_ctrl(ex_ctrl),
    .ex_memRead(ex_memRead), .ex_regWrite(ex_regWrite),
    .pc_stall(pc_stall), .ifid_stall(ifid_stall), .load_use_stall(load_use_stall)
`ifdef HAZARD_STATS_EN
    , .stall_count(stall_count), .flush_count(flush_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          valid;
    logic [31:0]   pc;
    logic [4:0]    rs1, rs2, rd;
    logic [31:0]   d1, d2, imm;
    logic [CW-1:0] ctrl;
    logic          mr, rw;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        m;
  logic [31:0] m_stall_cnt, m_flush_cnt;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic model_hazard();
    logic hit1, hit2;
    hit1 = id_uses_rs1 && (id_rs1 == m.rd);
    hit2 = id_uses_rs2 && (id_rs2 == m.rd);
    return id_valid && m.valid && m.mr && (m.rd != 5'd0) && (hit1 || hit2);
  endfunction

  task automatic compare_out();
    exp_t e;
    if (sb_q.size() == 0) begin
      check("sb_empty", 64'd1, 64'd0);
      return;
    end
    e = sb_q.pop_front();
    check("ex_valid", ex_valid, e.valid);
    check("ex_pc", ex_pc, e.pc);
    check("ex_rs1", ex_rs1, e.rs1);
    check("ex_rs2", ex_rs2, e.rs2);
    check("ex_rd", ex_rd, e.rd);
    check("ex_rs1_data", ex_rs1_data, e.d1);
    check("ex_rs2_data", ex_rs2_data, e.d2);
    check("ex_imm", ex_imm, e.imm);
    check("ex_ctrl", ex_ctrl, e.ctrl);
    check("ex_memRead", ex_memRead, e.mr);
    check("ex_regWrite", ex_regWrite, e.rw);
`ifdef HAZARD_STATS_EN
    check("stall_count", stall_count, m_stall_cnt);
    check("flush_count", flush_count, m_flush_cnt);
`endif
    m = e;
  endtask

  // One clock: check combinational stalls, predict the edge, compare after it.
  task automatic step();
    logic hz, exp_pcs, exp_lus;
    exp_t nx;
    #1;
    hz      = model_hazard();
    exp_pcs = !ex_flush && (ex_stall || hz);
    exp_lus = hz && !ex_flush && !ex_stall;
    check("pc_stall", pc_stall, exp_pcs);
    check("ifid_stall", ifid_stall, exp_pcs);
    check("load_use_stall", load_use_stall, exp_lus);
    if (ex_flush || (!ex_stall && hz)) nx = '0;
    else if (ex_stall) nx = m;
    else begin
      nx.valid = id_valid;  nx.pc = id_pc;
      nx.rs1 = id_rs1;  nx.rs2 = id_rs2;  nx.rd = id_rd;
      nx.d1 = (wb_regWrite && wb_rd != 5'd0 && wb_rd == id_rs1) ? wb_data : id_rs1_data;
      nx.d2 = (wb_regWrite && wb_rd != 5'd0 && wb_rd == id_rs2) ? wb_data : id_rs2_data;
      nx.imm = id_imm;  nx.ctrl = id_ctrl;  nx.mr = id_memRead;  nx.rw = id_regWrite;
    end
    if (exp_lus && m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt++;
    if (ex_flush && m.valid && m_flush_cnt != 32'hFFFF_FFFF) m_flush_cnt++;
    sb_q.push_back(nx);
    @(posedge clk);
    #1;
    compare_out();
  endtask

  task automatic set_id(input logic v, input logic [31:0] pc, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                        input logic mr, input logic rw);
    id_valid = v; id_pc = pc; id_rs1 = rs1; id_uses_rs1 = u1; id_rs2 = rs2; id_uses_rs2 = u2;
    id_rd = rd; id_memRead = mr; id_regWrite = rw;
    id_rs1_data = pc ^ 32'h1111_0000; id_rs2_data = pc ^ 32'h2222_0000;
    id_imm = pc + 32'd4; id_ctrl = pc[15:0] ^ 16'h5A5A;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    set_id(1'b0, 32'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    wb_regWrite = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
    ex_flush = 1'b0; ex_stall = 1'b0;
    m = '0; m_stall_cnt = '0; m_flush_cnt = '0;
    #12;
    check("rst_ex_valid", ex_valid, 1'b0);
    check("rst_ex_pc", ex_pc, 32'd0);
    check("rst_ex_ctrl", ex_ctrl, '0);
    rst_n = 1'b1;

    // Plain advance
    set_id(1'b1, 32'h100, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b0, 1'b1);
    id_imm = 32'h10;
    step();
    check("adv_ex_rd", ex_rd, 5'd5);
    check("adv_ex_imm", ex_imm, 32'h10);
    check("adv_ex_valid", ex_valid, 1'b1);

    // Load-use on rs2
    set_id(1'b1, 32'h104, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
    step();
    set_id(1'b1, 32'h108, 5'd1, 1'b1, 5'd7, 1'b1, 5'd8, 1'b0, 1'b1);
    #1 check("lu_stall", load_use_stall, 1'b1);
    step();
    check("lu_bubble", ex_valid, 1'b0);
    step();
    check("lu_advance_rs2", ex_rs2, 5'd7);
    check("lu_advance_valid", ex_valid, 1'b1);

    // Back-to-back dependent loads
    set_id(1'b1, 32'h200, 5'd0, 1'b0, 5'd0, 1'b0, 5'd2, 1'b1, 1'b1);
    step();
    set_id(1'b1, 32'h204, 5'd2, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1);
    step(); step();
    set_id(1'b1, 32'h208, 5'd3, 1'b1, 5'd0, 1'b0, 5'd9, 1'b0, 1'b1);
    step(); step();

    // x0 load and unused operand
    set_id(1'b1, 32'h300, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
    step();
    set_id(1'b1, 32'h304, 5'd0, 1'b1, 5'd0, 1'b1, 5'd6, 1'b0, 1'b1);
    #1 check("x0_no_stall", load_use_stall, 1'b0);
    step();
    set_id(1'b1, 32'h308, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1);
    step();
    set_id(1'b1, 32'h30C, 5'd4, 1'b0, 5'd1, 1'b1, 5'd6, 1'b0, 1'b1);
    #1 check("unused_no_stall", load_use_stall, 1'b0);
    step();

    // Flush with hazard and stall both asserted
    set_id(1'b1, 32'h400, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1);
    step();
    set_id(1'b1, 32'h404, 5'd6, 1'b1, 5'd0, 1'b0, 5'd1, 1'b0, 1'b1);
    ex_flush = 1'b1; ex_stall = 1'b1;
    #1 check("flush_pc_stall", pc_stall, 1'b0);
    step();
    check("flush_valid", ex_valid, 1'b0);
    check("flush_regWrite", ex_regWrite, 1'b0);
    ex_flush = 1'b0; ex_stall = 1'b0;

    // WB write-through bypass
    set_id(1'b1, 32'h500, 5'd3, 1'b1, 5'd4, 1'b1, 5'd1, 1'b0, 1'b1);
    id_rs1_data = 32'd0;
    wb_regWrite = 1'b1; wb_rd = 5'd3; wb_data = 32'hDEAD_BEEF;
    step();
    check("byp_rs1_data", ex_rs1_data, 32'hDEAD_BEEF);
    id_rs1 = 5'd0; wb_rd = 5'd0;
    step();
    check("byp_x0_data", ex_rs1_data, 32'd0);
    wb_regWrite = 1'b0;

    // Randomised traffic with a small register space to provoke hazards
    for (int i = 0; i < 300; i++) begin
      set_id($urandom_range(0, 3) != 0, $urandom, 5'($urandom_range(0, 3)), 1'($urandom),
             5'($urandom_range(0, 3)), 1'($urandom), 5'($urandom_range(0, 3)),
             1'($urandom), 1'($urandom));
      id_rs1_data = $urandom; id_rs2_data = $urandom;
      wb_regWrite = 1'($urandom); wb_rd = 5'($urandom_range(0, 3)); wb_data = $urandom;
      ex_flush = ($urandom_range(0, 9) == 0);
      ex_stall = ($urandom_range(0, 4) == 0);
      step();
    end

    // Asynchronous reset while EX holds a valid instruction under stall
    ex_flush = 1'b0; ex_stall = 1'b0; wb_regWrite = 1'b0;
    set_id(1'b1, 32'h600, 5'd1, 1'b0, 5'd2, 1'b0, 5'd5, 1'b0, 1'b1);
    step();
    ex_stall = 1'b1;
    step();
    #3 rst_n = 1'b0;
    #1;
    check("arst_ex_valid", ex_valid, 1'b0);
    check("arst_ex_pc", ex_pc, 32'd0);
    check("arst_ex_rd", ex_rd, 5'd0);
    check("arst_ex_imm", ex_imm, 32'd0);
    check("arst_ex_ctrl", ex_ctrl, '0);
    check("arst_ex_regWrite", ex_regWrite, 1'b0);
    check("arst_pc_stall", pc_stall, 1'b1);
`ifdef HAZARD_STATS_EN
    check("arst_stall_count", stall_count, 32'd0);
    check("arst_flush_count", flush_count, 32'd0);
`endif
    #2 rst_n = 1'b1;
    m = '0; m_stall_cnt = '0; m_flush_cnt = '0;
    ex_stall = 1'b0;
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/idex_hazard_stage.md
# idex_hazard_stage

ID/EX pipeline register with integrated load-use hazard detection and WB-to-ID write-through bypass. Sits directly upstream of the EX-stage forwarding logic: it registers decoded operands, register indices and write-enables, and presents them in EX as the rs1/rs2 indices and operand data that forwarding compares against EX/MEM and MEM/WB. It produces the only stall the forwarded pipeline needs, a one-cycle load-use bubble, and it honours branch flush and downstream stall requests.

## Interface
- CTRL_W, default 16: width of the opaque EX/MEM/WB control bundle carried through the register.
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_pc  in  32  PC of the ID instruction.
- id_rs1, id_rs2, id_rd  in  5 each  register indices.
- id_uses_rs1, id_uses_rs2  in  1 each  instruction actually reads rs1/rs2.
- id_rs1_data, id_rs2_data  in  32 each  register-file read data.
- id_imm  in  32  sign-extended immediate.
- id_ctrl  in  CTRL_W  control bundle.
- id_memRead, id_regWrite  in  1 each  load flag and write-enable.
- wb_regWrite  in  1; wb_rd  in  5; wb_data  in  32  write port currently committing.
- ex_flush  in  1  taken branch/jump redirect from EX.
- ex_stall  in  1  downstream hold, e.g. memory busy.
- ex_valid, ex_pc, ex_rs1, ex_rs2, ex_rd, ex_rs1_data, ex_rs2_data, ex_imm, ex_ctrl, ex_memRead, ex_regWrite  out  registered copies, widths as inputs.
- pc_stall, ifid_stall  out  1 each  hold PC and IF/ID.
- load_use_stall  out  1  hazard indicator, combinational.
- stall_count, flush_count  out  32 each  present only under HAZARD_STATS_EN.

## Operation
- hazard = id_valid & ex_valid & ex_memRead & (ex_rd != 0) & ((id_uses_rs1 & id_rs1 == ex_rd) | (id_uses_rs2 & id_rs2 == ex_rd)).
- Write-through bypass: when wb_regWrite & wb_rd != 0 & wb_rd == id_rsN, wb_data is captured instead of id_rsN_data, for N = 1, 2 independently.
- Next-state priority per edge:
  - ex_flush: load a bubble.
  - ex_stall: hold all registers.
  - hazard: load a bubble.
  - Otherwise: load ID values.
- Bubble: ex_valid=0, ex_memRead=0, ex_regWrite=0, ex_rd=0, ex_ctrl=0. Data fields are don't-care and are zeroed.
- pc_stall = ifid_stall = ~ex_flush & (ex_stall | hazard).
- load_use_stall = hazard & ~ex_flush & ~ex_stall.
- Flush overrides stall: the redirect must proceed.

## Timing
- Latency: one cycle, ID to ex_* outputs.
- Load-use costs exactly one bubble. In cycle N the hazard is detected. At edge N+1 the bubble enters EX and the ID instruction is held. In cycle N+1 the hazard is clear and the instruction advances at edge N+2.
- Back-to-back loads that each feed the next instruction produce one bubble per pair, never two consecutive bubbles.
- ex_stall during a hazard holds EX and does not insert a bubble. The hazard re-evaluates once ex_stall drops.
- Reset (async, any time, including mid-stall): all ex_* outputs 0, which is a bubble. Stall outputs then follow their combinational equations. Counters are 0.
- Writes to x0 never trigger hazard or bypass.

## Configuration
- HAZARD_STATS_EN defined:
  - stall_count increments on every cycle with load_use_stall=1.
  - flush_count increments on every cycle with ex_flush=1 & ex_valid=1.
  - Both counters saturate at 0xFFFF_FFFF.
- HAZARD_STATS_EN undefined: counter ports and logic are absent; all other behaviour is identical.

## Structure
- Shared package holds:
  - CTRL_W default.
  - Register-index width constant (5).
  - Zero/bubble constants for the bundle.
  - idex_t struct of registered fields, used for both the held value and the bubble value.
- One sub-module: load_use_detect, purely combinational, which computes hazard from the ID and EX indices and flags. The register, priority mux, bypass and counters stay in idex_hazard_stage.

## Test plan
- Plain advance: id_valid=1, id_rd=5, id_imm=0x10 -> ex_rd=5, ex_imm=0x10, ex_valid=1 one edge later; pc_stall=0.
- Load-use: EX holds a load to rd=7; ID has rs2=7, uses_rs2=1 -> load_use_stall=1; next edge ex_valid=0, ID held; following edge ID enters EX with ex_rs2=7.
- x0 and unused operand: EX load rd=0, or ID rs1 match with uses_rs1=0 -> no stall.
- Flush during hazard and ex_stall: ex_flush=1 together with hazard=1 and ex_stall=1 -> pc_stall=0; next edge ex_valid=0, ex_regWrite=0; flush_count +1 if enabled.
- WB bypass: wb_regWrite=1, wb_rd=3, wb_data=0xDEADBEEF; id_rs1=3, id_rs1_data=0 -> ex_rs1_data=0xDEADBEEF; with wb_rd=0 -> 0.
- Reset mid-stall: assert rst_n=0 while ex_stall=1 and EX is valid -> all ex_* outputs 0 immediately, without waiting for a clock edge; counters 0.
